// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   key_state_t : 5-bit key state (valid flag + hex code)
//   KEY_NONE    : "no key" state (valid=0, code=0)
//   KEY_MAP     : 16-entry hex code map indexed by {row, col}
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned DB_W   = 4;

    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } key_state_t;

    localparam key_state_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

    // Nibble {r,c} holds the legend of the key at row r, column c.
    // row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
    localparam logic [15:0][CODE_W-1:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [CODE_W-1:0] key_lookup(input logic [1:0] r,
                                                     input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// kp_debounce: accepts a frame result only after DEBOUNCE_SCANS identical frames.
//   clk, rst        : clock, synchronous active-high reset
//   i_frame_res     : key state resolved by the last scan frame
//   i_frame_end     : strobe, i_frame_res is valid this cycle
//   o_key           : last accepted key code
//   o_key_valid     : one-cycle pulse when a new key is accepted
//   o_key_held      : high while the accepted state is a pressed key
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  key_state_t        i_frame_res,
    input  logic              i_frame_end,
    output logic [CODE_W-1:0] o_key,
    output logic              o_key_valid,
    output logic              o_key_held
);

    key_state_t        r_cand;
    key_state_t        r_stable;
    logic [DB_W-1:0]   r_cnt_db;

    key_state_t        w_cand_nxt;
    key_state_t        w_stable_nxt;
    logic [DB_W-1:0]   w_cnt_nxt;
    logic [CODE_W-1:0] w_key_nxt;
    logic              w_valid_nxt;

    // Candidate tracking and acceptance, evaluated once per frame
    always_comb begin
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt_db;
        w_key_nxt    = o_key;
        w_valid_nxt  = 1'b0;
        if (i_frame_end) begin
            if (i_frame_res != r_cand) begin
                w_cand_nxt = i_frame_res;
                w_cnt_nxt  = DB_W'(1);
            end else if (r_cnt_db < DB_W'(DEBOUNCE_SCANS)) begin
                w_cnt_nxt = r_cnt_db + DB_W'(1);
            end
            // Acceptance uses the updated count so DEBOUNCE_SCANS=1 accepts at once
            if ((w_cnt_nxt == DB_W'(DEBOUNCE_SCANS)) && (w_cand_nxt != r_stable)) begin
                w_stable_nxt = w_cand_nxt;
                if (w_cand_nxt.valid) begin
                    w_key_nxt   = w_cand_nxt.code;
                    w_valid_nxt = 1'b1;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand      <= KEY_NONE;
            r_stable    <= KEY_NONE;
            r_cnt_db    <= '0;
            o_key       <= '0;
            o_key_valid <= 1'b0;
            o_key_held  <= 1'b0;
        end else begin
            r_cand      <= w_cand_nxt;
            r_stable    <= w_stable_nxt;
            r_cnt_db    <= w_cnt_nxt;
            o_key       <= w_key_nxt;
            o_key_valid <= w_valid_nxt;
            o_key_held  <= w_stable_nxt.valid;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: column-scanning driver and debouncer for a 4x4 active-low keypad.
//   clk, rst   : clock, synchronous active-high reset
//   row        : keypad rows, active-low, asynchronous
//   col        : keypad columns, active-low, one low at a time
//   key        : last accepted key code (hex)
//   key_valid  : one-cycle pulse per accepted key
//   key_held   : high while a key is accepted as pressed
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 20000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key,
    output logic              key_valid,
    output logic              key_held
);

    localparam int unsigned CNT_W = $clog2(SCAN_TICKS + 1);

    logic [ROWS-1:0]  r_row_s1;
    logic [ROWS-1:0]  r_row_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [COLS-1:0]  r_col;
    key_state_t       r_hit;

    logic             w_sample;
    logic             w_frame_end;
    logic             w_any;
    logic [1:0]       w_row_idx;
    key_state_t       w_hit_nxt;

    // Two-flop synchronizer, idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Dwell counter and column select; col rotates in step with sel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= 2'd0;
            r_col <= 4'b1110;
        end else if (w_sample) begin
            r_cnt <= '0;
            r_sel <= r_sel + 2'd1;
            r_col <= {r_col[COLS-2:0], r_col[COLS-1]};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Lowest-index active row, and first-hit latch for the frame
    always_comb begin
        w_sample    = (r_cnt == CNT_W'(SCAN_TICKS));
        w_frame_end = w_sample && (r_sel == 2'd3);
        w_any       = 1'b0;
        w_row_idx   = 2'd0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (!r_row_s2[i] && !w_any) begin
                w_any     = 1'b1;
                w_row_idx = 2'(i);
            end
        end
        w_hit_nxt = r_hit;
        if (w_sample && !r_hit.valid && w_any) begin
            w_hit_nxt = '{valid: 1'b1, code: key_lookup(w_row_idx, r_sel)};
        end
    end

    // Hit latch clears at frame end; the frame result includes the last column
    always_ff @(posedge clk) begin
        if (rst || w_frame_end) begin
            r_hit <= KEY_NONE;
        end else begin
            r_hit <= w_hit_nxt;
        end
    end

    assign col = r_col;

    kp_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_frame_res (w_hit_nxt),
        .i_frame_end (w_frame_end),
        .o_key       (key),
        .o_key_valid (key_valid),
        .o_key_held  (key_held)
    );

endmodule
